// File: rtl/divisor_sequencial_if.sv
// rtl/divisor_sequencial_if.sv - start/operand/result signal bundle for the sequential 8/4 divider
interface divisor_sequencial_if;
  logic       inicio;
  logic [7:0] a;
  logic [3:0] b;
  logic [7:0] q;
  logic [3:0] r;
  logic       ocupado;
  logic       pronto;
  logic       div_zero;

  modport master (
    output inicio, a, b,
    input  q, r, ocupado, pronto, div_zero
  );

  modport slave (
    input  inicio, a, b,
    output q, r, ocupado, pronto, div_zero
  );
endinterface

// File: rtl/divisor_sequencial.sv
// rtl/divisor_sequencial.sv - 8-bit / 4-bit unsigned restoring divider, one quotient bit per cycle
// Optional zero-divisor early termination under macro DIVISOR_ZERO_CHECK_EN.
module divisor_sequencial (
  input logic                 clk,
  input logic                 rst,
  divisor_sequencial_if.slave dif
);
  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    FIM     = 2'd2
  } state_t;

  state_t     state_q, state_d;
  // Dividend bits shift out at the MSB while quotient bits shift in at the LSB.
  logic [7:0] dq_q, dq_d;
  logic [3:0] b_q, b_d;
  logic [3:0] p_q, p_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] q_q, q_d;
  logic [3:0] r_q, r_d;
`ifdef DIVISOR_ZERO_CHECK_EN
  logic       dz_q, dz_d;
`endif

  logic [4:0] trial;
  logic [3:0] diff;
  logic       qbit;

  always_comb begin
    trial   = {p_q, dq_q[7]};
    // When trial >= b the difference is below b, so four bits hold it exactly.
    diff    = trial[3:0] - b_q;
    qbit    = (trial >= {1'b0, b_q});
    state_d = state_q;
    dq_d    = dq_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
`ifdef DIVISOR_ZERO_CHECK_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      OCIOSO: begin
        if (dif.inicio) begin
          dq_d    = dif.a;
          b_d     = dif.b;
          p_d     = 4'd0;
          cnt_d   = 3'd0;
          state_d = CALCULA;
`ifdef DIVISOR_ZERO_CHECK_EN
          if (dif.b == 4'd0) begin
            state_d = FIM;
            q_d     = 8'hFF;
            r_d     = dif.a[3:0];
            dz_d    = 1'b1;
          end
`endif
        end
      end
      CALCULA: begin
        p_d   = qbit ? diff : trial[3:0];
        dq_d  = {dq_q[6:0], qbit};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = FIM;
          q_d     = {dq_q[6:0], qbit};
          r_d     = qbit ? diff : trial[3:0];
`ifdef DIVISOR_ZERO_CHECK_EN
          dz_d    = 1'b0;
`endif
        end
      end
      FIM:     state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OCIOSO;
      dq_q    <= 8'd0;
      b_q     <= 4'd0;
      p_q     <= 4'd0;
      cnt_q   <= 3'd0;
      q_q     <= 8'd0;
      r_q     <= 4'd0;
`ifdef DIVISOR_ZERO_CHECK_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dq_q    <= dq_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
`ifdef DIVISOR_ZERO_CHECK_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign dif.q       = q_q;
  assign dif.r       = r_q;
  assign dif.ocupado = (state_q == CALCULA);
  assign dif.pronto  = (state_q == FIM);
`ifdef DIVISOR_ZERO_CHECK_EN
  assign dif.div_zero = dz_q;
`else
  assign dif.div_zero = 1'b0;
`endif
endmodule

// File: tb/tb_divisor_sequencial.sv
// tb/tb_divisor_sequencial.sv - directed and random checks for divisor_sequencial
module tb_divisor_sequencial;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  divisor_sequencial_if dif ();
  divisor_sequencial dut (.clk(clk), .rst(rst), .dif(dif));

  int n_vec = 0;
  int n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request, scrambles a/b after E0, and observes until pronto falls.
  task automatic do_op(input logic [7:0] ta, input logic [3:0] tb_,
                       output logic [7:0] oq, output logic [3:0] orr, output logic odz,
                       output int busy, output int npr, output int first_pr,
                       output bit held, output bit done);
    logic [7:0] q0;
    logic [3:0] r0;
    q0 = dif.q; r0 = dif.r;
    busy = 0; npr = 0; first_pr = -1; held = 1'b1; done = 1'b0;
    oq = '0; orr = '0; odz = 1'b0;
    dif.a = ta; dif.b = tb_; dif.inicio = 1'b1;
    step();
    dif.inicio = 1'b0;
    dif.a = ~ta; dif.b = ~tb_;
    for (int k = 0; k < 20 && !done; k++) begin
      if (dif.ocupado) begin
        busy++;
        if (dif.q !== q0 || dif.r !== r0) held = 1'b0;
      end
      if (dif.pronto) begin
        if (npr == 0) first_pr = k;
        npr++;
        oq = dif.q; orr = dif.r; odz = dif.div_zero;
      end else if (npr > 0) begin
        done = 1'b1;
      end
      if (!done) step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; dif.inicio = 1'b0; dif.a = 8'h5A; dif.b = 4'h3;
    step(); step();
    n_vec++; if (dif.q !== 8'd0) begin n_err++; $display("FAIL reset_q got %h want 00", dif.q); end
    n_vec++; if (dif.r !== 4'd0) begin n_err++; $display("FAIL reset_r got %h want 0", dif.r); end
    n_vec++; if (dif.ocupado !== 1'b0) begin n_err++; $display("FAIL reset_ocupado got %b want 0", dif.ocupado); end
    n_vec++; if (dif.pronto !== 1'b0) begin n_err++; $display("FAIL reset_pronto got %b want 0", dif.pronto); end
    n_vec++; if (dif.div_zero !== 1'b0) begin n_err++; $display("FAIL reset_div_zero got %b want 0", dif.div_zero); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_directed();
    logic [7:0] va[7] = '{8'd200, 8'd255, 8'd5, 8'd255, 8'd0, 8'd14, 8'd128};
    logic [3:0] vb[7] = '{4'd7, 4'd15, 4'd9, 4'd1, 4'd5, 4'd15, 4'd8};
    logic [7:0] eq[7] = '{8'd28, 8'd17, 8'd0, 8'd255, 8'd0, 8'd0, 8'd16};
    logic [3:0] er[7] = '{4'd4, 4'd0, 4'd5, 4'd0, 4'd0, 4'd14, 4'd0};
    logic [7:0] oq; logic [3:0] orr; logic odz;
    int busy, npr, fp; bit held, done;
    for (int i = 0; i < 7; i++) begin
      do_op(va[i], vb[i], oq, orr, odz, busy, npr, fp, held, done);
      n_vec++; if (!done) begin n_err++; $display("FAIL dir%0d_timeout got done=%b want 1", i, done); end
      n_vec++; if (busy != 8) begin n_err++; $display("FAIL dir%0d_busy got %0d want 8", i, busy); end
      n_vec++; if (npr != 1 || fp != 8) begin n_err++; $display("FAIL dir%0d_pronto got n=%0d at %0d want n=1 at 8", i, npr, fp); end
      n_vec++; if (oq !== eq[i]) begin n_err++; $display("FAIL dir%0d_q got %0d want %0d", i, oq, eq[i]); end
      n_vec++; if (orr !== er[i]) begin n_err++; $display("FAIL dir%0d_r got %0d want %0d", i, orr, er[i]); end
      n_vec++; if (odz !== 1'b0) begin n_err++; $display("FAIL dir%0d_div_zero got %b want 0", i, odz); end
      n_vec++; if (!held) begin n_err++; $display("FAIL dir%0d_hold got changed want stable", i); end
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] oq; logic [3:0] orr; logic odz;
    int busy, npr, fp; bit held, done;
`ifdef DIVISOR_ZERO_CHECK_EN
    int  ebusy = 0; int efp = 0; logic edz = 1'b1;
`else
    int  ebusy = 8; int efp = 8; logic edz = 1'b0;
`endif
    do_op(8'hAB, 4'd0, oq, orr, odz, busy, npr, fp, held, done);
    n_vec++; if (!done) begin n_err++; $display("FAIL dz_timeout got done=%b want 1", done); end
    n_vec++; if (busy != ebusy) begin n_err++; $display("FAIL dz_busy got %0d want %0d", busy, ebusy); end
    n_vec++; if (npr != 1 || fp != efp) begin n_err++; $display("FAIL dz_pronto got n=%0d at %0d want n=1 at %0d", npr, fp, efp); end
    n_vec++; if (oq !== 8'hFF) begin n_err++; $display("FAIL dz_q got %h want ff", oq); end
    n_vec++; if (orr !== 4'hB) begin n_err++; $display("FAIL dz_r got %h want b", orr); end
    n_vec++; if (odz !== edz) begin n_err++; $display("FAIL dz_flag got %b want %b", odz, edz); end
    n_vec++; if (dif.div_zero !== edz) begin n_err++; $display("FAIL dz_flag_hold got %b want %b", dif.div_zero, edz); end
    do_op(8'd200, 4'd7, oq, orr, odz, busy, npr, fp, held, done);
    n_vec++; if (odz !== 1'b0) begin n_err++; $display("FAIL dz_clear got %b want 0", odz); end
    n_vec++; if (oq !== 8'd28 || orr !== 4'd4) begin n_err++; $display("FAIL dz_next got q=%0d r=%0d want q=28 r=4", oq, orr); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] oq; logic [3:0] orr;
    int busy, npr; bit done;
    busy = 0; npr = 0; done = 1'b0; oq = '0; orr = '0;
    dif.a = 8'd100; dif.b = 4'd3; dif.inicio = 1'b1;
    step();
    dif.inicio = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (dif.ocupado) busy++;
      if (dif.pronto) begin npr++; oq = dif.q; orr = dif.r; end
      else if (npr > 0) done = 1'b1;
      dif.inicio = (k == 2);
      if (k == 2) begin dif.a = 8'd9; dif.b = 4'd2; end
      if (!done) step();
    end
    dif.inicio = 1'b0;
    n_vec++; if (!done) begin n_err++; $display("FAIL b2b_timeout got done=%b want 1", done); end
    n_vec++; if (busy != 8) begin n_err++; $display("FAIL b2b_busy got %0d want 8", busy); end
    n_vec++; if (npr != 1) begin n_err++; $display("FAIL b2b_pronto got %0d want 1", npr); end
    n_vec++; if (oq !== 8'd33 || orr !== 4'd1) begin n_err++; $display("FAIL b2b_result got q=%0d r=%0d want q=33 r=1", oq, orr); end
    step();
    n_vec++; if (dif.ocupado !== 1'b0) begin n_err++; $display("FAIL b2b_no_queue got %b want 0", dif.ocupado); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] oq; logic [3:0] orr; logic odz;
    int busy, npr, fp, seen; bit held, done;
    dif.a = 8'd100; dif.b = 4'd3; dif.inicio = 1'b1;
    step();
    dif.inicio = 1'b0;
    step(); step(); step();
    rst = 1'b1; dif.inicio = 1'b1;
    step();
    rst = 1'b0; dif.inicio = 1'b0;
    n_vec++; if (dif.q !== 8'd0 || dif.r !== 4'd0) begin n_err++; $display("FAIL abort_qr got q=%0d r=%0d want 0 0", dif.q, dif.r); end
    n_vec++; if (dif.ocupado !== 1'b0 || dif.pronto !== 1'b0 || dif.div_zero !== 1'b0)
      begin n_err++; $display("FAIL abort_flags got %b%b%b want 000", dif.ocupado, dif.pronto, dif.div_zero); end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (dif.pronto || dif.ocupado) seen++;
    end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL abort_quiet got %0d active cycles want 0", seen); end
    do_op(8'd200, 4'd7, oq, orr, odz, busy, npr, fp, held, done);
    n_vec++; if (!done || oq !== 8'd28 || orr !== 4'd4)
      begin n_err++; $display("FAIL abort_restart got q=%0d r=%0d done=%b want q=28 r=4 done=1", oq, orr, done); end
  endtask

  task automatic test_random();
    logic [7:0] oq; logic [3:0] orr; logic odz;
    logic [7:0] ra; logic [3:0] rb;
    int busy, npr, fp; bit held, done;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 4'($urandom_range(1, 15));
      do_op(ra, rb, oq, orr, odz, busy, npr, fp, held, done);
      n_vec++; if (!done || npr != 1) begin n_err++; $display("FAIL rnd%0d_handshake got done=%b n=%0d want 1 1", i, done, npr); end
      n_vec++; if (oq !== ra / {4'd0, rb}) begin n_err++; $display("FAIL rnd%0d_q %0d/%0d got %0d want %0d", i, ra, rb, oq, ra / {4'd0, rb}); end
      n_vec++; if ({4'd0, orr} !== ra % {4'd0, rb}) begin n_err++; $display("FAIL rnd%0d_r %0d%%%0d got %0d want %0d", i, ra, rb, orr, ra % {4'd0, rb}); end
    end
  endtask

  initial begin
    rst = 1'b1; dif.inicio = 1'b0; dif.a = '0; dif.b = '0;
    test_reset();
    test_directed();
    test_div_zero();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
